// File: rtl/oserdes_tx_feeder_if.sv
// Word-stream interface feeding oserdes_tx_feeder.
// Handshake: a word (S_DATA, S_LAST) transfers on a rising clock edge where
// S_VALID and S_READY are both 1. The master holds S_DATA/S_LAST stable while
// S_VALID=1 and S_READY=0. S_READY never depends on S_VALID.
interface oserdes_tx_feeder_if #(
  parameter int DATA_WIDTH = 4
);
  logic [DATA_WIDTH-1:0] S_DATA;
  logic                  S_LAST;
  logic                  S_VALID;
  logic                  S_READY;

  modport master (output S_DATA, output S_LAST, output S_VALID, input S_READY);
  modport slave  (input S_DATA, input S_LAST, input S_VALID, output S_READY);
endinterface

// File: rtl/oserdes_tx_feeder.sv
// oserdes_tx_feeder: buffers parallel words in a small FIFO and plays them
// into an OSERDES (D1..D6, T1..T4) as framed bursts:
// IDLE -> PRE (one idle word, drivers on) -> BURST (one word per cycle)
// -> POST (one idle word, drivers on) -> IDLE.
// Optional feature: define OSERDES_TX_FEEDER_WC_EN to generate the WC
// write-command pulse during the PRE cycle; otherwise WC is tied to 0.
module oserdes_tx_feeder #(
  parameter int                    DATA_WIDTH   = 4,
  parameter int                    FIFO_DEPTH   = 4,
  parameter int                    START_LEVEL  = 2,
  parameter logic [DATA_WIDTH-1:0] IDLE_PATTERN = '0
) (
  input  logic                  CLKDIV,
  input  logic                  RSTN,
  oserdes_tx_feeder_if.slave    s,
  output logic                  D1,
  output logic                  D2,
  output logic                  D3,
  output logic                  D4,
  output logic                  D5,
  output logic                  D6,
  output logic                  T1,
  output logic                  T2,
  output logic                  T3,
  output logic                  T4,
  output logic                  OCE,
  output logic                  TCE,
  output logic                  WC,
  output logic                  BUSY,
  output logic                  UNDERRUN,
  input  logic                  UNDERRUN_CLR,
  output logic [1:0]            dbg_state_o
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] START_C = CW'(START_LEVEL);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRE   = 2'd1,
    ST_BURST = 2'd2,
    ST_POST  = 2'd3
  } state_t;

  // FIFO storage: {last, data} per entry
  logic [DATA_WIDTH:0]   mem_q [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]         count_q, count_d;
  logic [CW-1:0]         last_cnt_q, last_cnt_d;

  // Output / control registers
  state_t                state_q;
  logic [DATA_WIDTH-1:0] d_q;
  logic                  t_q;
  logic                  busy_q;
  logic                  last_out_q;   // word currently on D closes the frame
  logic                  underrun_q;
  logic                  run_q;        // 1 from the first edge after reset release

  logic                  push, pop, fifo_empty, start_burst, pop_slot, underrun_set;
  logic [DATA_WIDTH-1:0] head_data;
  logic                  head_last;
  logic [5:0]            d_ext;

  assign fifo_empty   = (count_q == '0);
  assign s.S_READY    = run_q && (count_q < DEPTH_C);
  assign push         = s.S_VALID && s.S_READY;
  assign head_data    = mem_q[rd_ptr_q][DATA_WIDTH-1:0];
  assign head_last    = mem_q[rd_ptr_q][DATA_WIDTH];
  // A pop slot is every cycle that loads a new data word onto D
  assign pop_slot     = (state_q == ST_PRE) || ((state_q == ST_BURST) && !last_out_q);
  assign pop          = pop_slot && !fifo_empty;
  assign underrun_set = pop_slot && fifo_empty;
  assign start_burst  = (count_q >= START_C) || (last_cnt_q != '0);

  // Next occupancy and queued-LAST count; push+pop leaves them unchanged
  always_comb begin
    count_d    = count_q;
    last_cnt_d = last_cnt_q;
    if (push && !pop) count_d = count_q + 1'b1;
    else if (!push && pop) count_d = count_q - 1'b1;
    if ((push && s.S_LAST) && !(pop && head_last)) last_cnt_d = last_cnt_q + 1'b1;
    else if (!(push && s.S_LAST) && (pop && head_last)) last_cnt_d = last_cnt_q - 1'b1;
  end

  // FIFO storage write; contents are don't-care once pointers are reset
  always_ff @(posedge CLKDIV) begin
    if (push) mem_q[wr_ptr_q] <= {s.S_LAST, s.S_DATA};
  end

  // FIFO pointers and counters; reset discards every queued word
  always_ff @(posedge CLKDIV or negedge RSTN) begin
    if (!RSTN) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      last_cnt_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q    <= count_d;
      last_cnt_q <= last_cnt_d;
    end
  end

  // Run flag: enables the FIFO and the serializer clock enables
  always_ff @(posedge CLKDIV or negedge RSTN) begin
    if (!RSTN) run_q <= 1'b0;
    else       run_q <= 1'b1;
  end

  // Burst FSM with registered D/T/BUSY outputs
  always_ff @(posedge CLKDIV or negedge RSTN) begin
    if (!RSTN) begin
      state_q    <= ST_IDLE;
      d_q        <= IDLE_PATTERN;
      t_q        <= 1'b1;
      busy_q     <= 1'b0;
      last_out_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          d_q <= IDLE_PATTERN;
          if (start_burst) begin
            state_q <= ST_PRE;
            t_q     <= 1'b0;
            busy_q  <= 1'b1;
          end else begin
            t_q     <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        ST_PRE, ST_BURST: begin
          t_q    <= 1'b0;
          busy_q <= 1'b1;
          if ((state_q == ST_BURST) && last_out_q) begin
            state_q    <= ST_POST;
            d_q        <= IDLE_PATTERN;
            last_out_q <= 1'b0;
          end else begin
            state_q <= ST_BURST;
            if (!fifo_empty) begin
              d_q        <= head_data;
              last_out_q <= head_last;
            end else begin
              d_q        <= IDLE_PATTERN;
              last_out_q <= 1'b0;
            end
          end
        end
        ST_POST: begin
          state_q <= ST_IDLE;
          d_q     <= IDLE_PATTERN;
          t_q     <= 1'b1;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          d_q     <= IDLE_PATTERN;
          t_q     <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Sticky underrun flag; a new underrun beats a simultaneous clear
  always_ff @(posedge CLKDIV or negedge RSTN) begin
    if (!RSTN)             underrun_q <= 1'b0;
    else if (underrun_set) underrun_q <= 1'b1;
    else if (UNDERRUN_CLR) underrun_q <= 1'b0;
  end

`ifdef OSERDES_TX_FEEDER_WC_EN
  logic wc_q;
  // Write-command pulse coincident with the PRE cycle
  always_ff @(posedge CLKDIV or negedge RSTN) begin
    if (!RSTN) wc_q <= 1'b0;
    else       wc_q <= (state_q == ST_IDLE) && start_burst;
  end
  assign WC = wc_q;
`else
  assign WC = 1'b0;
`endif

  // Zero-extend the word onto the six serializer data inputs
  always_comb begin
    d_ext                 = '0;
    d_ext[DATA_WIDTH-1:0] = d_q;
  end

  assign D1 = d_ext[0];
  assign D2 = d_ext[1];
  assign D3 = d_ext[2];
  assign D4 = d_ext[3];
  assign D5 = d_ext[4];
  assign D6 = d_ext[5];
  assign T1 = t_q;
  assign T2 = t_q;
  assign T3 = t_q;
  assign T4 = t_q;
  assign OCE = run_q;
  assign TCE = run_q;
  assign BUSY = busy_q;
  assign UNDERRUN = underrun_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_oserdes_tx_feeder.sv
// Testbench for oserdes_tx_feeder: directed vector table, multi-cycle
// corner sequences (FIFO full, async reset mid-burst) and a randomized run
// against a queue-based reference model.
module tb_oserdes_tx_feeder;

  localparam int DW    = 4;
  localparam int DEPTH = 4;
  localparam int START = 2;
`ifdef OSERDES_TX_FEEDER_WC_EN
  localparam bit WC_ON = 1'b1;
`else
  localparam bit WC_ON = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- DUT (default parameters) ----------------
  oserdes_tx_feeder_if #(.DATA_WIDTH(DW)) bus ();
  logic d1, d2, d3, d4, d5, d6, t1, t2, t3, t4, oce, tce, wc, busy, und, clr;
  logic [1:0] dbg;

  oserdes_tx_feeder #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .START_LEVEL(START)) u_dut (
    .CLKDIV(clk), .RSTN(rst_n), .s(bus),
    .D1(d1), .D2(d2), .D3(d3), .D4(d4), .D5(d5), .D6(d6),
    .T1(t1), .T2(t2), .T3(t3), .T4(t4),
    .OCE(oce), .TCE(tce), .WC(wc), .BUSY(busy),
    .UNDERRUN(und), .UNDERRUN_CLR(clr), .dbg_state_o(dbg)
  );

  // ---------------- DUT with START_LEVEL = FIFO_DEPTH ----------------
  oserdes_tx_feeder_if #(.DATA_WIDTH(DW)) bus_b ();
  logic d1_b, d2_b, d3_b, d4_b, d5_b, d6_b, t1_b, t2_b, t3_b, t4_b;
  logic oce_b, tce_b, wc_b, busy_b, und_b, clr_b;
  logic [1:0] dbg_b;

  oserdes_tx_feeder #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .START_LEVEL(4)) u_dut4 (
    .CLKDIV(clk), .RSTN(rst_n), .s(bus_b),
    .D1(d1_b), .D2(d2_b), .D3(d3_b), .D4(d4_b), .D5(d5_b), .D6(d6_b),
    .T1(t1_b), .T2(t2_b), .T3(t3_b), .T4(t4_b),
    .OCE(oce_b), .TCE(tce_b), .WC(wc_b), .BUSY(busy_b),
    .UNDERRUN(und_b), .UNDERRUN_CLR(clr_b), .dbg_state_o(dbg_b)
  );

  logic [5:0] d_bus, d_bus_b;
  logic [3:0] t_bus, t_bus_b;
  assign d_bus   = {d6, d5, d4, d3, d2, d1};
  assign t_bus   = {t4, t3, t2, t1};
  assign d_bus_b = {d6_b, d5_b, d4_b, d3_b, d2_b, d1_b};
  assign t_bus_b = {t4_b, t3_b, t2_b, t1_b};

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [DW-1:0] exp_q[$];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Compare the main DUT's registered outputs against expectations
  task automatic chk_out(input string p, input logic [5:0] ed, input logic et,
                         input logic eb, input logic eu, input logic ew);
    chk({p, ".d"},    8'(d_bus), 8'(ed));
    chk({p, ".t"},    8'(t_bus), 8'({4{et}}));
    chk({p, ".busy"}, 8'(busy),  8'(eb));
    chk({p, ".und"},  8'(und),   8'(eu));
    chk({p, ".wc"},   8'(wc),    8'(ew && WC_ON));
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] dat, input logic lst, input logic c);
    bus.S_VALID = v;
    bus.S_DATA  = dat;
    bus.S_LAST  = lst;
    clr         = c;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic          v;
    logic [DW-1:0] data;
    logic          last;
    logic          clr;
    logic [5:0]    exp_d;
    logic          exp_t;
    logic          exp_busy;
    logic          exp_und;
    logic          pre;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(input logic v, input logic [DW-1:0] data, input logic last,
                              input logic c, input logic [5:0] ed, input logic et,
                              input logic eb, input logic eu, input logic pre);
    vec_t r;
    r.v = v; r.data = data; r.last = last; r.clr = c;
    r.exp_d = ed; r.exp_t = et; r.exp_busy = eb; r.exp_und = eu; r.pre = pre;
    tbl.push_back(r);
  endfunction

  // ---------------- FIFO-full sequence on the START_LEVEL=4 instance ----------------
  task automatic run_fill();
    int idx = 0;
    logic acc;
    logic [DW-1:0] e;
    for (int w = 1; w <= 5; w++) exp_q.push_back(DW'(w));
    for (int cyc = 0; cyc < 12; cyc++) begin
      bus_b.S_VALID = (idx < 5);
      bus_b.S_DATA  = DW'(idx + 1);
      bus_b.S_LAST  = (idx == 4);
      if (cyc <= 6) chk($sformatf("fill.rdy%0d", cyc), 8'(bus_b.S_READY), 8'(cyc != 4 && cyc != 5));
      acc = bus_b.S_VALID && bus_b.S_READY;
      step();
      if (acc) idx++;
      if (cyc >= 5 && cyc <= 9) begin
        e = exp_q.pop_front();
        chk($sformatf("fill.d%0d", cyc), 8'(d_bus_b), 8'(e));
        chk($sformatf("fill.t%0d", cyc), 8'(t_bus_b), 8'h0);
      end else if (cyc == 4 || cyc == 10) begin
        chk($sformatf("fill.d%0d", cyc), 8'(d_bus_b), 8'h0);
        chk($sformatf("fill.t%0d", cyc), 8'(t_bus_b), 8'h0);
      end else if (cyc == 11) begin
        chk("fill.t_end", 8'(t_bus_b), 8'hF);
        chk("fill.busy_end", 8'(busy_b), 8'h0);
      end
    end
    bus_b.S_VALID = 1'b0;
    chk("fill.accepted", 8'(idx), 8'd5);
    chk("fill.sb_empty", 8'(exp_q.size()), 8'd0);
  endtask

  // ---------------- randomized run against a queue model ----------------
  task automatic run_random(input int n);
    logic [DW:0]   mq[$];       // queued words {last, data}
    int            phase = 0;   // 0 idle, 1 pre, 2 burst, 3 post
    bit            frame_done = 0;
    bit            m_run = 0, m_und = 0;
    logic [5:0]    m_d;
    logic          m_t, m_busy, m_wc, m_rdy, push, has_last;
    logic          v, lst, c;
    logic [DW-1:0] dat;
    logic [DW:0]   w;
    int            sz;
    for (int i = 0; i < n; i++) begin
      v   = ($urandom_range(0, 99) < 60);
      dat = DW'($urandom_range(0, (1 << DW) - 1));
      lst = ($urandom_range(0, 5) == 0);
      c   = ($urandom_range(0, 15) == 0);
      drive(v, dat, lst, c);
      m_rdy = m_run && (mq.size() < DEPTH);
      chk($sformatf("rnd%0d.rdy", i), 8'(bus.S_READY), 8'(m_rdy));
      push = v && m_rdy;
      sz = mq.size();
      has_last = 1'b0;
      foreach (mq[k]) if (mq[k][DW]) has_last = 1'b1;
      m_wc = 1'b0;
      m_d  = '0;
      case (phase)
        0: begin
          if (sz >= START || has_last) begin
            phase = 1; m_t = 1'b0; m_busy = 1'b1; m_wc = 1'b1;
          end else begin
            m_t = 1'b1; m_busy = 1'b0;
          end
        end
        1, 2: begin
          m_t = 1'b0; m_busy = 1'b1;
          if (phase == 2 && frame_done) begin
            phase = 3; frame_done = 0;
          end else begin
            phase = 2;
            if (sz > 0) begin
              w = mq.pop_front();
              m_d = 6'(w[DW-1:0]);
              frame_done = w[DW];
            end else begin
              m_und = 1'b1;
              c = 1'b0;          // an underrun outranks a clear request
            end
          end
        end
        default: begin
          phase = 0; m_t = 1'b1; m_busy = 1'b0;
        end
      endcase
      if (c) m_und = 1'b0;
      if (push) mq.push_back({lst, dat});
      m_run = 1'b1;
      step();
      chk_out($sformatf("rnd%0d", i), m_d, m_t, m_busy, m_und, m_wc);
    end
    drive(1'b0, '0, 1'b0, 1'b0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    drive(1'b0, '0, 1'b0, 1'b0);
    bus_b.S_VALID = 1'b0; bus_b.S_DATA = '0; bus_b.S_LAST = 1'b0; clr_b = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk_out("reset", 6'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("reset.oce", 8'(oce), 8'h0);
    chk("reset.tce", 8'(tce), 8'h0);
    chk("reset.rdy", 8'(bus.S_READY), 8'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("release.rdy_before_edge", 8'(bus.S_READY), 8'h0);

    // v  data  last clr | d    t  busy und pre
    add(0, 4'h0, 0, 0,    6'h0, 1, 0,   0,  0);  // first edge after release
    add(1, 4'h5, 0, 0,    6'h0, 1, 0,   0,  0);  // frame 5,A,3(LAST)
    add(1, 4'hA, 0, 0,    6'h0, 1, 0,   0,  0);
    add(1, 4'h3, 1, 0,    6'h0, 0, 1,   0,  1);  // level 2 reached -> PRE
    add(0, 4'h0, 0, 0,    6'h5, 0, 1,   0,  0);
    add(0, 4'h0, 0, 0,    6'hA, 0, 1,   0,  0);
    add(0, 4'h0, 0, 0,    6'h3, 0, 1,   0,  0);
    add(0, 4'h0, 0, 0,    6'h0, 0, 1,   0,  0);  // POST
    add(0, 4'h0, 0, 0,    6'h0, 1, 0,   0,  0);
    add(1, 4'h9, 1, 0,    6'h0, 1, 0,   0,  0);  // single LAST word below level
    add(0, 4'h0, 0, 0,    6'h0, 0, 1,   0,  1);
    add(0, 4'h0, 0, 0,    6'h9, 0, 1,   0,  0);
    add(0, 4'h0, 0, 0,    6'h0, 0, 1,   0,  0);
    add(0, 4'h0, 0, 0,    6'h0, 1, 0,   0,  0);
    add(1, 4'h6, 0, 0,    6'h0, 1, 0,   0,  0);  // two words, then stall
    add(1, 4'hC, 0, 0,    6'h0, 1, 0,   0,  0);
    add(0, 4'h0, 0, 0,    6'h0, 0, 1,   0,  1);
    add(0, 4'h0, 0, 0,    6'h6, 0, 1,   0,  0);
    add(0, 4'h0, 0, 0,    6'hC, 0, 1,   0,  0);
    add(0, 4'h0, 0, 0,    6'h0, 0, 1,   1,  0);  // underrun
    add(0, 4'h0, 0, 1,    6'h0, 0, 1,   1,  0);  // clear loses to set
    add(0, 4'h0, 0, 0,    6'h0, 0, 1,   1,  0);
    add(1, 4'hE, 1, 0,    6'h0, 0, 1,   1,  0);  // LAST word arrives
    add(0, 4'h0, 0, 0,    6'hE, 0, 1,   1,  0);
    add(0, 4'h0, 0, 0,    6'h0, 0, 1,   1,  0);
    add(0, 4'h0, 0, 0,    6'h0, 1, 0,   1,  0);
    add(0, 4'h0, 0, 1,    6'h0, 1, 0,   0,  0);  // clear while idle
    add(0, 4'h0, 0, 0,    6'h0, 1, 0,   0,  0);

    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].data, tbl[i].last, tbl[i].clr);
      step();
      chk_out($sformatf("vec%0d", i), tbl[i].exp_d, tbl[i].exp_t, tbl[i].exp_busy,
              tbl[i].exp_und, tbl[i].pre);
      chk($sformatf("vec%0d.rdy", i), 8'(bus.S_READY), 8'h1);
      chk($sformatf("vec%0d.oce", i), 8'({oce, tce}), 8'h3);
    end
    drive(1'b0, '0, 1'b0, 1'b0);

    // FIFO full with no pop, fifth word must survive
    run_fill();

    // Asynchronous reset in the middle of a burst
    drive(1'b1, 4'h7, 1'b0, 1'b0); step();
    drive(1'b1, 4'h8, 1'b0, 1'b0); step();
    drive(1'b1, 4'h2, 1'b0, 1'b0); step();
    drive(1'b1, 4'h4, 1'b0, 1'b0); step();
    drive(1'b0, 4'h0, 1'b0, 1'b0); step();
    chk_out("midburst", 6'h8, 1'b0, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk_out("async_rst", 6'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("async_rst.oce", 8'({oce, tce}), 8'h0);
    chk("async_rst.rdy", 8'(bus.S_READY), 8'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk_out("post_rst.idle", 6'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 4'h1, 1'b1, 1'b0); step();
    drive(1'b0, 4'h0, 1'b0, 1'b0);
    chk_out("post_rst.push", 6'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(); chk_out("post_rst.pre",   6'h0, 1'b0, 1'b1, 1'b0, 1'b1);
    step(); chk_out("post_rst.burst", 6'h1, 1'b0, 1'b1, 1'b0, 1'b0);
    step(); chk_out("post_rst.post",  6'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      step();
      chk_out($sformatf("post_rst.idle%0d", k), 6'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    end

    // Randomized traffic from a fresh reset
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run_random(400);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
